// File: rtl/seq_divider.sv
// seq_divider: signed restoring divider, one quotient bit per cycle; data_remainder port only with DIV_REMAINDER_EN.
// Latency: data_resultRDY pulses WIDTH+1 cycles after an accepted start (1 cycle for divide-by-zero).
// Backpressure: none; ctrl_DIV is ignored while busy and accepted again in the RDY cycle.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
`ifdef DIV_REMAINDER_EN
  ,
  output logic [WIDTH-1:0] data_remainder
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

  state_t           state, state_nxt;
  logic             start;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] r, q, b_mag;
  logic             sign_a, sign_b, div0, exc;

  logic [WIDTH-1:0] a_mag_in, b_mag_in;
  logic [WIDTH:0]   r_shift, r_diff;
  logic [WIDTH-1:0] q_fix;

  // Two's-complement negation of the most negative value yields 2^(W-1) read as unsigned.
  assign a_mag_in = data_operandA[WIDTH-1] ? (~data_operandA + 1'b1) : data_operandA;
  assign b_mag_in = data_operandB[WIDTH-1] ? (~data_operandB + 1'b1) : data_operandB;

  assign r_shift = {r, q[WIDTH-1]};
  assign r_diff  = r_shift - {1'b0, b_mag};
  assign q_fix   = (sign_a ^ sign_b) ? (~q + 1'b1) : q;

  assign busy = (state != IDLE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    case (state)
      IDLE: begin
        if (ctrl_DIV) begin
          start     = 1'b1;
          state_nxt = (data_operandB == '0) ? FIX : ITER;
        end
      end
      ITER:    if (cnt == CNT_LAST) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef DIV_REMAINDER_EN
  logic [WIDTH-1:0] rem_mag;
  // With a zero divisor the iteration is skipped and q still holds |A|.
  assign rem_mag = div0 ? q : r;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt            <= '0;
      r              <= '0;
      q              <= '0;
      b_mag          <= '0;
      sign_a         <= 1'b0;
      sign_b         <= 1'b0;
      div0           <= 1'b0;
      exc            <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
`ifdef DIV_REMAINDER_EN
      data_remainder <= '0;
`endif
    end else begin
      data_resultRDY <= 1'b0;
      if (start) begin
        cnt    <= '0;
        r      <= '0;
        q      <= a_mag_in;
        b_mag  <= b_mag_in;
        sign_a <= data_operandA[WIDTH-1];
        sign_b <= data_operandB[WIDTH-1];
        div0   <= (data_operandB == '0);
        exc    <= (data_operandB == '0) ||
                  ((data_operandA == MIN_VAL) && (data_operandB == '1));
      end else if (state == ITER) begin
        cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
        q   <= {q[WIDTH-2:0], ~r_diff[WIDTH]};
        r   <= r_diff[WIDTH] ? r_shift[WIDTH-1:0] : r_diff[WIDTH-1:0];
      end else if (state == FIX) begin
        data_result    <= div0 ? '0 : q_fix;
        data_exception <= exc;
        data_resultRDY <= 1'b1;
`ifdef DIV_REMAINDER_EN
        data_remainder <= sign_a ? (~rem_mag + 1'b1) : rem_mag;
`endif
      end
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: vector table, random ops against an arithmetic model, corner sequences.
module tb_seq_divider;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        ctrl_DIV;
  logic [31:0] opA, opB;
  logic [31:0] data_result;
  logic        data_exception, data_resultRDY, busy;
`ifdef DIV_REMAINDER_EN
  logic [31:0] data_remainder;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  seq_divider #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (opA),
    .data_operandB  (opB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
`ifdef DIV_REMAINDER_EN
    ,
    .data_remainder (data_remainder)
`endif
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_q;
    logic [31:0] exp_r;
    logic        exp_e;
    int          exp_lat;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain signed arithmetic with the two exception cases carved out.
  task automatic model(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] q, output logic [31:0] r, output logic e);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (b == 32'd0) begin
      q = 32'd0; r = a; e = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 32'd0; e = 1'b1;
    end else begin
      q = 32'(sa / sb); r = 32'(sa % sb); e = 1'b0;
    end
  endtask

  // Called at a negedge; returns at the negedge of the RDY cycle (or on timeout).
  task automatic do_div(input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int busy_cnt);
    ctrl_DIV = 1'b1; opA = a; opB = b;
    @(posedge clock);
    @(negedge clock);
    ctrl_DIV = 1'b0;
    opA = $urandom; opB = $urandom;
    lat = 0; busy_cnt = 0;
    while (!data_resultRDY && lat < 100) begin
      if (busy) busy_cnt++;
      @(negedge clock);
      lat++;
    end
  endtask

  task automatic check_op(input string tag, input int lat, input int busy_cnt,
                          input logic [31:0] eq, input logic [31:0] er,
                          input logic ee, input int elat);
    check({tag, " latency"}, 64'(lat), 64'(elat));
    check({tag, " busy cycles"}, 64'(busy_cnt), 64'(elat));
    check({tag, " busy in RDY cycle"}, 64'(busy), 64'd0);
    check({tag, " result"}, 64'(data_result), 64'(eq));
    check({tag, " exception"}, 64'(data_exception), 64'(ee));
`ifdef DIV_REMAINDER_EN
    check({tag, " remainder"}, 64'(data_remainder), 64'(er));
`else
    if (er === 32'hx) $display("unexpected X in expected remainder for %s", tag);
`endif
  endtask

  initial begin
    int lat, bc, rdy_seen;
    logic [31:0] a, b, eq, er;
    logic ee;

    vecs[0]  = '{32'd100,       32'd7,          32'd14,         32'd2,          1'b0, 33};
    vecs[1]  = '{32'hFFFF_FF9C, 32'd7,          32'hFFFF_FFF2,  32'hFFFF_FFFE,  1'b0, 33};
    vecs[2]  = '{32'd100,       32'hFFFF_FFF9,  32'hFFFF_FFF2,  32'd2,          1'b0, 33};
    vecs[3]  = '{32'd55,        32'd0,          32'd0,          32'd55,         1'b1, 1};
    vecs[4]  = '{32'h8000_0000, 32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b1, 33};
    vecs[5]  = '{32'h8000_0000, 32'd1,          32'h8000_0000,  32'd0,          1'b0, 33};
    vecs[6]  = '{32'd7,         32'd100,        32'd0,          32'd7,          1'b0, 33};
    vecs[7]  = '{32'hFFFF_FFF9, 32'd0,          32'd0,          32'hFFFF_FFF9,  1'b1, 1};
    vecs[8]  = '{32'h7FFF_FFFF, 32'h8000_0000,  32'd0,          32'h7FFF_FFFF,  1'b0, 33};
    vecs[9]  = '{32'h8000_0000, 32'h8000_0000,  32'd1,          32'd0,          1'b0, 33};
    vecs[10] = '{32'hFFFF_FF9C, 32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  1'b0, 33};

    reset_n = 1'b0; ctrl_DIV = 1'b0; opA = '0; opB = '0;
    repeat (2) @(negedge clock);
    check("reset result", 64'(data_result), 64'd0);
    check("reset exception", 64'(data_exception), 64'd0);
    check("reset rdy", 64'(data_resultRDY), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    reset_n = 1'b1;
    @(negedge clock);

    for (int i = 0; i < 11; i++) begin
      do_div(vecs[i].a, vecs[i].b, lat, bc);
      check_op($sformatf("vec%0d", i), lat, bc, vecs[i].exp_q, vecs[i].exp_r,
               vecs[i].exp_e, vecs[i].exp_lat);
      @(negedge clock);
      check($sformatf("vec%0d rdy pulse ends", i), 64'(data_resultRDY), 64'd0);
      check($sformatf("vec%0d result holds", i), 64'(data_result), 64'(vecs[i].exp_q));
    end

    for (int i = 0; i < 25; i++) begin
      case ($urandom_range(0, 3))
        0:       begin a = $urandom; b = 32'($urandom_range(1, 20)); end
        1:       begin a = $urandom; b = $urandom; end
        2:       begin a = 32'($signed($urandom_range(0, 2000)) - 1000);
                       b = 32'($signed($urandom_range(0, 20)) - 10); end
        default: begin a = $urandom; b = 32'hFFFF_FFFF - 32'($urandom_range(0, 3)); end
      endcase
      model(a, b, eq, er, ee);
      // Random ops run back to back: each starts in the previous RDY cycle.
      do_div(a, b, lat, bc);
      check_op($sformatf("rand%0d %0h/%0h", i, a, b), lat, bc, eq, er, ee, (b == 0) ? 1 : 33);
    end

    // Start pulsed mid-operation must be dropped.
    @(negedge clock);
    ctrl_DIV = 1'b1; opA = 32'd9; opB = 32'd3;
    @(posedge clock);
    @(negedge clock);
    ctrl_DIV = 1'b0;
    repeat (9) @(negedge clock);
    ctrl_DIV = 1'b1; opA = 32'd8; opB = 32'd2;
    @(posedge clock);
    @(negedge clock);
    ctrl_DIV = 1'b0;
    lat = 10;
    while (!data_resultRDY && lat < 100) begin
      @(negedge clock);
      lat++;
    end
    check("ignored start latency", 64'(lat), 64'd33);
    check("ignored start result", 64'(data_result), 64'd3);

    do_div(32'd8, 32'd2, lat, bc);
    check_op("restart in RDY cycle", lat, bc, 32'd4, 32'd0, 1'b0, 33);

    // Reset in the middle of an operation aborts it without a RDY pulse.
    ctrl_DIV = 1'b1; opA = 32'd100; opB = 32'd7;
    @(posedge clock);
    @(negedge clock);
    ctrl_DIV = 1'b0;
    repeat (15) @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("abort result", 64'(data_result), 64'd0);
    check("abort exception", 64'(data_exception), 64'd0);
    check("abort rdy", 64'(data_resultRDY), 64'd0);
    check("abort busy", 64'(busy), 64'd0);
`ifdef DIV_REMAINDER_EN
    check("abort remainder", 64'(data_remainder), 64'd0);
`endif
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    rdy_seen = 0;
    repeat (40) begin
      @(negedge clock);
      if (data_resultRDY || busy) rdy_seen++;
    end
    check("no RDY after abort", 64'(rdy_seen), 64'd0);

    do_div(32'd20, 32'd4, lat, bc);
    check_op("after reset 20/4", lat, bc, 32'd5, 32'd0, 1'b0, 33);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
